// File: rtl/memwb_load_align_pkg.sv
// rtl/memwb_load_align_pkg.sv - shared load funct3 codes, WB state enum and WB register bundle
package memwb_load_align_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        PASS = 1'b0,
        HOLD = 1'b1
    } wb_state_e;

    typedef struct packed {
        logic [31:0] alu;
        logic [2:0]  funct3;
        logic [4:0]  write_addr;
        logic        mem_read;
        logic        mem_to_reg;
        logic        reg_write;
    } wb_regs_t;

    // Any code other than the byte/halfword forms is treated as a word access.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr,
                                           input logic       mem_read);
        logic mis;
        mis = 1'b0;
        if (mem_read) begin
            case (funct3)
                F3_LB, F3_LBU: mis = 1'b0;
                F3_LH, F3_LHU: mis = addr[0];
                default:       mis = (addr != 2'b00);
            endcase
        end
        return mis;
    endfunction

endpackage

// File: rtl/memwb_load_align_load_extract.sv
// rtl/memwb_load_align_load_extract.sv - combinational load lane select and sign/zero extension
module load_extract
    import memwb_load_align_pkg::*;
(
    input  logic [31:0] dm_do_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = dm_do_i[7:0];
        case (addr_i)
            2'b00: byte_lane = dm_do_i[7:0];
            2'b01: byte_lane = dm_do_i[15:8];
            2'b10: byte_lane = dm_do_i[23:16];
            2'b11: byte_lane = dm_do_i[31:24];
            default: byte_lane = dm_do_i[7:0];
        endcase
    end

    assign half_lane = addr_i[1] ? dm_do_i[31:16] : dm_do_i[15:0];

    always_comb begin
        data_o = dm_do_i;
        case (funct3_i)
            F3_LB:   data_o = {{24{byte_lane[7]}}, byte_lane};
            F3_LBU:  data_o = {24'h000000, byte_lane};
            F3_LH:   data_o = {{16{half_lane[15]}}, half_lane};
            F3_LHU:  data_o = {16'h0000, half_lane};
            default: data_o = dm_do_i;
        endcase
    end

endmodule

// File: rtl/memwb_load_align.sv
// rtl/memwb_load_align.sv - MEM/WB pipeline register with load alignment and stall hold buffer
// Optional misaligned-load trap enabled by defining MISALIGN_TRAP_EN.
module memwb_load_align
    import memwb_load_align_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] MEM_ALU_out,
    input  logic [2:0]  MEM_funct3,
    input  logic [4:0]  MEM_write_addr,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemtoReg,
    input  logic        MEM_RegWrite,
    input  logic [31:0] DM_DO,
    input  logic        im_stall,
    input  logic        dm_stall,
    input  logic        CSR_stall,
    input  logic        CSR_reset,
    output logic [31:0] WB_rd_data,
    output logic [4:0]  WB_write_addr,
    output logic        WB_RegWrite,
    output logic        WB_misalign
);

    wb_regs_t    wb_q, wb_d, mem_in;
    wb_state_e   state_q, state_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] aligned;
    logic [31:0] load_val;
    logic        stall;
    logic        misalign;

    assign stall = im_stall | dm_stall | CSR_stall;

    always_comb begin
        mem_in            = '0;
        mem_in.alu        = MEM_ALU_out;
        mem_in.funct3     = MEM_funct3;
        mem_in.write_addr = MEM_write_addr;
        mem_in.mem_read   = MEM_MemRead;
        mem_in.mem_to_reg = MEM_MemtoReg;
        mem_in.reg_write  = MEM_RegWrite;
    end

    load_extract u_load_extract (
        .dm_do_i  (DM_DO),
        .addr_i   (wb_q.alu[1:0]),
        .funct3_i (wb_q.funct3),
        .data_o   (aligned)
    );

    // Flush beats stall; stall beats advance. Leaving HOLD advances on the same edge.
    always_comb begin
        wb_d    = wb_q;
        state_d = state_q;
        hold_d  = hold_q;
        if (CSR_reset) begin
            wb_d    = '0;
            state_d = PASS;
            hold_d  = '0;
        end else begin
            case (state_q)
                PASS: begin
                    if (stall) begin
                        state_d = HOLD;
                        hold_d  = aligned;
                    end else begin
                        wb_d = mem_in;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        state_d = PASS;
                        wb_d    = mem_in;
                    end
                end
                default: state_d = PASS;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_q    <= '0;
            state_q <= PASS;
            hold_q  <= '0;
        end else begin
            wb_q    <= wb_d;
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

`ifdef MISALIGN_TRAP_EN
    assign misalign = is_misaligned(wb_q.funct3, wb_q.alu[1:0], wb_q.mem_read);
`else
    logic unused_mem_read;
    assign unused_mem_read = wb_q.mem_read;
    assign misalign        = 1'b0;
`endif

    assign load_val      = (state_q == HOLD) ? hold_q : aligned;
    assign WB_rd_data    = wb_q.mem_to_reg ? load_val : wb_q.alu;
    assign WB_write_addr = wb_q.write_addr;
    assign WB_RegWrite   = wb_q.reg_write & ~misalign;
    assign WB_misalign   = misalign;

endmodule

// File: tb/tb_memwb_load_align.sv
// tb/tb_memwb_load_align.sv - directed self-checking bench for memwb_load_align
module tb_memwb_load_align;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] MEM_ALU_out;
    logic [2:0]  MEM_funct3;
    logic [4:0]  MEM_write_addr;
    logic        MEM_MemRead, MEM_MemtoReg, MEM_RegWrite;
    logic [31:0] DM_DO;
    logic        im_stall, dm_stall, CSR_stall, CSR_reset;
    logic [31:0] WB_rd_data;
    logic [4:0]  WB_write_addr;
    logic        WB_RegWrite;
    logic        WB_misalign;

    int checks = 0;
    int errors = 0;

`ifdef MISALIGN_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    memwb_load_align dut (
        .clk            (clk),
        .reset          (reset),
        .MEM_ALU_out    (MEM_ALU_out),
        .MEM_funct3     (MEM_funct3),
        .MEM_write_addr (MEM_write_addr),
        .MEM_MemRead    (MEM_MemRead),
        .MEM_MemtoReg   (MEM_MemtoReg),
        .MEM_RegWrite   (MEM_RegWrite),
        .DM_DO          (DM_DO),
        .im_stall       (im_stall),
        .dm_stall       (dm_stall),
        .CSR_stall      (CSR_stall),
        .CSR_reset      (CSR_reset),
        .WB_rd_data     (WB_rd_data),
        .WB_write_addr  (WB_write_addr),
        .WB_RegWrite    (WB_RegWrite),
        .WB_misalign    (WB_misalign)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_mem(input logic [2:0] f3, input logic [31:0] addr,
                             input logic rd, input logic m2r, input logic rw,
                             input logic [4:0] wa);
        MEM_funct3     = f3;
        MEM_ALU_out    = addr;
        MEM_MemRead    = rd;
        MEM_MemtoReg   = m2r;
        MEM_RegWrite   = rw;
        MEM_write_addr = wa;
    endtask

    // MEM cycle, then memory data arrives in the following (WB) cycle.
    task automatic do_load(input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] data, input logic [4:0] wa);
        drive_mem(f3, addr, 1'b1, 1'b1, 1'b1, wa);
        step();
        DM_DO = data;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive_mem(3'b000, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        DM_DO = 32'h0;
        im_stall = 1'b0; dm_stall = 1'b0; CSR_stall = 1'b0; CSR_reset = 1'b0;
        #12;
        check_val("reset_rd_data", WB_rd_data, 32'h0);
        check_val("reset_waddr", {27'h0, WB_write_addr}, 32'h0);
        check_val("reset_regwrite", {31'h0, WB_RegWrite}, 32'h0);
        check_val("reset_misalign", {31'h0, WB_misalign}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        do_load(3'b000, 32'h0000_1003, 32'h80FF_FFFF, 5'd5);
        check_val("lb_lane3", WB_rd_data, 32'hFFFF_FF80);
        check_val("lb_waddr", {27'h0, WB_write_addr}, 32'd5);
        check_val("lb_regwrite", {31'h0, WB_RegWrite}, 32'd1);
        do_load(3'b100, 32'h0000_1003, 32'h80FF_FFFF, 5'd5);
        check_val("lbu_lane3", WB_rd_data, 32'h0000_0080);
        do_load(3'b001, 32'h0000_1002, 32'h8001_1234, 5'd6);
        check_val("lh_upper", WB_rd_data, 32'hFFFF_8001);
        do_load(3'b101, 32'h0000_1002, 32'h8001_1234, 5'd6);
        check_val("lhu_upper", WB_rd_data, 32'h0000_8001);
        do_load(3'b000, 32'h0000_1000, 32'h0000_007F, 5'd7);
        check_val("lb_lane0_pos", WB_rd_data, 32'h0000_007F);
        do_load(3'b000, 32'h0000_1001, 32'h0000_9A00, 5'd7);
        check_val("lb_lane1_neg", WB_rd_data, 32'hFFFF_FF9A);
        do_load(3'b001, 32'h0000_1000, 32'h1234_F00D, 5'd7);
        check_val("lh_lower", WB_rd_data, 32'hFFFF_F00D);

        drive_mem(3'b000, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 5'd12);
        step();
        DM_DO = 32'hFFFF_FFFF;
        #1;
        check_val("alu_pass", WB_rd_data, 32'h1234_5678);
        check_val("alu_waddr", {27'h0, WB_write_addr}, 32'd12);
        drive_mem(3'b000, 32'h0000_0042, 1'b0, 1'b0, 1'b1, 5'd0);
        step();
        check_val("x0_regwrite", {31'h0, WB_RegWrite}, 32'd1);

        do_load(3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 5'd7);
        check_val("lw_live", WB_rd_data, 32'hDEAD_BEEF);
        drive_mem(3'b000, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b1, 5'd9);
        dm_stall = 1'b1;
        step();
        DM_DO = 32'h0;
        #1;
        check_val("stall_hold_1", WB_rd_data, 32'hDEAD_BEEF);
        check_val("stall_waddr", {27'h0, WB_write_addr}, 32'd7);
        for (int i = 2; i <= 3; i++) begin
            step();
            check_val($sformatf("stall_hold_%0d", i), WB_rd_data, 32'hDEAD_BEEF);
        end
        dm_stall = 1'b0;
        step();
        check_val("stall_release", WB_rd_data, 32'hCAFE_F00D);
        check_val("stall_release_waddr", {27'h0, WB_write_addr}, 32'd9);

        do_load(3'b010, 32'h0000_0200, 32'h55AA_55AA, 5'd3);
        CSR_stall = 1'b1;
        step();
        DM_DO = 32'h0;
        #1;
        check_val("csr_hold", WB_rd_data, 32'h55AA_55AA);
        CSR_reset = 1'b1;
        step();
        check_val("flush_regwrite", {31'h0, WB_RegWrite}, 32'd0);
        check_val("flush_rd_data", WB_rd_data, 32'h0);
        check_val("flush_waddr", {27'h0, WB_write_addr}, 32'd0);
        CSR_reset = 1'b0;
        CSR_stall = 1'b0;
        do_load(3'b100, 32'h0000_0201, 32'h0000_AB00, 5'd4);
        check_val("post_flush_live_a", WB_rd_data, 32'h0000_00AB);
        DM_DO = 32'h0000_1200;
        #1;
        check_val("post_flush_live_b", WB_rd_data, 32'h0000_0012);

        do_load(3'b010, 32'h0000_0101, 32'h1122_3344, 5'd8);
        check_val("mis_lw_data", WB_rd_data, 32'h1122_3344);
        check_val("mis_lw_flag", {31'h0, WB_misalign}, {31'h0, TRAP});
        check_val("mis_lw_regwrite", {31'h0, WB_RegWrite}, {31'h0, ~TRAP});
        dm_stall = 1'b1;
        step();
        check_val("mis_held_flag", {31'h0, WB_misalign}, {31'h0, TRAP});
        dm_stall = 1'b0;
        do_load(3'b001, 32'h0000_0103, 32'h8001_1234, 5'd8);
        check_val("mis_lh_data", WB_rd_data, 32'hFFFF_8001);
        check_val("mis_lh_flag", {31'h0, WB_misalign}, {31'h0, TRAP});
        do_load(3'b000, 32'h0000_0103, 32'h8001_1234, 5'd8);
        check_val("lb_odd_not_mis", {31'h0, WB_misalign}, 32'd0);

        do_load(3'b010, 32'h0000_0300, 32'h0BAD_F00D, 5'd6);
        im_stall = 1'b1;
        step();
        DM_DO = 32'h0000_0001;
        #1;
        check_val("pre_reset_hold", WB_rd_data, 32'h0BAD_F00D);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("async_rst_rd_data", WB_rd_data, 32'h0);
        check_val("async_rst_waddr", {27'h0, WB_write_addr}, 32'h0);
        check_val("async_rst_regwrite", {31'h0, WB_RegWrite}, 32'h0);
        check_val("async_rst_misalign", {31'h0, WB_misalign}, 32'h0);
        #2;
        reset = 1'b0;
        im_stall = 1'b0;
        drive_mem(3'b010, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        #1;
        check_val("post_rst_rd_data", WB_rd_data, 32'h0);
        do_load(3'b010, 32'h0000_0400, 32'h7777_8888, 5'd2);
        check_val("post_rst_pass_live", WB_rd_data, 32'h7777_8888);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
